// File: rtl/vec_mem_unit_if.sv
// Bus between the processor control / data RAM and the vector/scalar memory unit.
// Handshake: a start is one cycle of cl_mem_st=1 and is taken only while mem_rdy=1;
// mem_rdy=0 means busy; mem_rdy=1 after a load means the result registers are valid.
interface vec_mem_unit_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 8,
    parameter int ADDR_W = 16
);
    logic                    cl_mem_st;
    logic [1:0]              cl_mem_op;
    logic [ADDR_W-1:0]       mem_addr;
    logic [LANES*DATA_W-1:0] vec_wdata;
    logic [DATA_W-1:0]       esc_wdata;
    logic                    mem_rdy;
    logic [LANES*DATA_W-1:0] vec_rdata;
    logic [DATA_W-1:0]       esc_rdata;
    logic [ADDR_W-1:0]       ram_addr;
    logic                    ram_re;
    logic                    ram_we;
    logic [DATA_W-1:0]       ram_wdata;
    logic [DATA_W-1:0]       ram_rdata;

    modport slave (
        input  cl_mem_st, cl_mem_op, mem_addr, vec_wdata, esc_wdata, ram_rdata,
        output mem_rdy, vec_rdata, esc_rdata, ram_addr, ram_re, ram_we, ram_wdata
    );

    modport master (
        output cl_mem_st, cl_mem_op, mem_addr, vec_wdata, esc_wdata, ram_rdata,
        input  mem_rdy, vec_rdata, esc_rdata, ram_addr, ram_re, ram_we, ram_wdata
    );
endinterface

// File: rtl/vec_mem_unit.sv
// Memory execution unit: moves one vector or one scalar between operands and a
// single-port synchronous RAM, one element per cycle, holding mem_rdy low while busy.
module vec_mem_unit #(
    parameter int DATA_W = 8,
    parameter int LANES  = 8,
    parameter int ADDR_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    vec_mem_unit_if.slave   bus,
    output logic [1:0]      dbg_state
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IDX_W  = LANE_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_RDW  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t                  state, state_nx;
    logic [IDX_W-1:0]        idx, idx_nx, last_idx;
    logic                    scalar_q;
    logic [ADDR_W-1:0]       base_q;
    logic [LANES*DATA_W-1:0] vwd_q, vec_q;
    logic [DATA_W-1:0]       swd_q, esc_q;
    logic [LANE_W-1:0]       wr_lane, cap_lane;
    logic                    capture;

    assign last_idx = scalar_q ? '0 : IDX_W'(LANES - 1);
    assign wr_lane  = idx[LANE_W-1:0];
    // Read data returns one cycle late, so it always belongs to lane idx-1.
    assign cap_lane = LANE_W'(idx - IDX_W'(1));
    assign capture  = ((state == S_RD) && (idx != '0)) || (state == S_RDW);

    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        bus.mem_rdy   = 1'b0;
        bus.ram_re    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        case (state)
            S_IDLE: begin
                bus.mem_rdy = 1'b1;
                if (bus.cl_mem_st) begin
                    idx_nx   = '0;
                    state_nx = bus.cl_mem_op[1] ? S_RD : S_WR;
                end
            end
            S_RD: begin
                bus.ram_re   = 1'b1;
                bus.ram_addr = base_q + ADDR_W'(idx);
                idx_nx       = idx + IDX_W'(1);
                if (idx == last_idx) state_nx = S_RDW;
            end
            S_RDW: begin
                state_nx = S_IDLE;
            end
            S_WR: begin
                bus.ram_we    = 1'b1;
                bus.ram_addr  = base_q + ADDR_W'(idx);
                bus.ram_wdata = scalar_q ? swd_q : vwd_q[wr_lane*DATA_W +: DATA_W];
                idx_nx        = idx + IDX_W'(1);
                if (idx == last_idx) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            scalar_q <= 1'b0;
            base_q   <= '0;
            vwd_q    <= '0;
            swd_q    <= '0;
            vec_q    <= '0;
            esc_q    <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if ((state == S_IDLE) && bus.cl_mem_st) begin
                scalar_q <= bus.cl_mem_op[0];
                base_q   <= bus.mem_addr;
                vwd_q    <= bus.vec_wdata;
                swd_q    <= bus.esc_wdata;
            end
            if (capture) begin
                if (scalar_q) esc_q <= bus.ram_rdata;
                else          vec_q[cap_lane*DATA_W +: DATA_W] <= bus.ram_rdata;
            end
        end
    end

    assign bus.vec_rdata = vec_q;
    assign bus.esc_rdata = esc_q;
    assign dbg_state     = state;
endmodule

// File: doc/vec_mem_unit.md
# vec_mem_unit

Vector/scalar memory execution unit: the responder side of the processor control's memory start/ready handshake. It accepts a one-cycle `cl_mem_st` with a 2-bit memory op, and moves one vector (LANES elements) or one scalar between the register-file operands and a single-port synchronous data RAM, one element per cycle. It holds `mem_rdy` low while busy, which stalls the pipeline and gates the vector/scalar register write enables in the execute stage.

## Interface
- DATA_W, 8, element and scalar width in bits
- LANES, 8, elements per vector
- ADDR_W, 16, RAM word-address width

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cl_mem_st  in  1  start request, sampled only when mem_rdy=1
- cl_mem_op  in  2  10 load vector, 11 load scalar, 00 store vector, 01 store scalar
- mem_addr  in  ADDR_W  base word address
- vec_wdata  in  LANES*DATA_W  store-vector operand, lane i = bits [i*DATA_W +: DATA_W]
- esc_wdata  in  DATA_W  store-scalar operand
- mem_rdy  out  1  1 = idle/result valid; 0 = transfer in progress
- vec_rdata  out  LANES*DATA_W  load-vector result
- esc_rdata  out  DATA_W  load-scalar result
- ram_addr  out  ADDR_W  RAM address
- ram_re  out  1  RAM read strobe
- ram_we  out  1  RAM write strobe
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_re

## Operation
- States: IDLE, RD (issue reads), RDW (capture last read), WR (issue writes).
- IDLE: mem_rdy=1, ram_re=ram_we=0. On cl_mem_st=1: latch cl_mem_op, mem_addr, vec_wdata, esc_wdata; clear lane index; go RD (ops 1x) or WR (ops 0x).
- RD: ram_re=1, ram_addr=base+idx; idx increments each cycle. Loads are LANES reads (vector) or 1 read (scalar). After the last issue go RDW.
- Capture: in every cycle following a read issue (RD cycles 2..N and RDW), ram_rdata is written into lane idx-1 of vec_rdata (vector) or into esc_rdata (scalar). RDW -> IDLE.
- WR: ram_we=1, ram_addr=base+idx, ram_wdata=latched lane idx (vector) or latched esc_wdata (scalar). LANES writes (vector) or 1 write (scalar). After the last write go IDLE.
- Address arithmetic: base+idx is modulo 2^ADDR_W (0xFFFF+1 = 0x0000). Lane 0 maps to the base address.
- Results hold until overwritten by a later load of the same kind. Scalar loads leave vec_rdata unchanged. Vector loads leave esc_rdata unchanged. Stores change neither.
- cl_mem_st while mem_rdy=0 is ignored and not queued. Operand inputs are don't-care after the start cycle.
- Reset (any state, including mid-transfer): state IDLE, idx 0, mem_rdy=1, ram_re=ram_we=0, ram_addr=0, ram_wdata=0, vec_rdata=0, esc_rdata=0. RAM contents written before the reset are not restored.

## Timing
- Start accepted at edge of cycle 0; mem_rdy=0 from cycle 1.
- Load vector: reads issued cycles 1..LANES, last capture cycle LANES+1, mem_rdy=1 with vec_rdata valid in cycle LANES+2 (10 for LANES=8).
- Load scalar: read cycle 1, capture cycle 2, mem_rdy=1 and esc_rdata valid cycle 3.
- Store vector: writes cycles 1..LANES, mem_rdy=1 cycle LANES+1.
- Store scalar: write cycle 1, mem_rdy=1 cycle 2.
- Back-to-back: a start sampled in the first mem_rdy=1 cycle is accepted, so there are no idle bubbles beyond that cycle.
- ram_re and ram_we are never high in the same cycle.

## Test plan
- Reset then idle: after rst, mem_rdy=1, all outputs 0, and no RAM strobes for 20 cycles.
- Store vector then load vector: store vec 0x0807060504030201 at 0x0010. Require ram_we in cycles 1-8 at 0x0010..0x0017 with data 01..08, and mem_rdy high at cycle 9. Then load 0x0010: require vec_rdata=0x0807060504030201 and mem_rdy=1 at cycle 10.
- Scalar store/load: store 0xA5 at 0x0042 (mem_rdy at cycle 2), then load from 0x0042. Require esc_rdata=0xA5 at cycle 3 and vec_rdata unchanged.
- Wrap-around: vector store at base 0xFFFC. Require addresses FFFC..FFFF, 0000..0003; reload from 0xFFFC returns identical data.
- Busy start ignored: pulse cl_mem_st with op 01 at cycle 3 of a vector store. Require no extra write and mem_rdy at cycle 9 only.
- Reset mid-load: assert rst at cycle 4 of a vector load. Next cycle require mem_rdy=1, ram_re=0, vec_rdata=0; a fresh load then completes normally.
